tx_ilas_sequencer: RTL and testbench
====================================

// Module: tx_ilas_sequencer
// PURPOSE
//  Generates the JESD204B initial lane alignment sequence (ILAS), one octet per char clock.
//  tx_control starts it on an LMFC boundary when link_mux selects ILA; output feeds the link-layer mux/8b10b input.
//  Emits multiframes framed by /R/ ... /A/; multiframe 2 carries /Q/ plus 14 config octets with computed FCHK.
// PARAMETERS
//  CFG_OCTETS   14   link config octets in multiframe 2 (fixed by standard; not overridable in practice)
//  MFLEN_W      14   width of multiframe octet counter; covers (F+1)*(K+1) <= 8192
// PORTS
//  clk                    in   1    character clock (1.25GHz); all logic on rising edge
//  rst                    in   1    asynchronous, active-high reset
//  i_start                in   1    1-cycle pulse; coincides with an LMFC boundary
//  i_abort                in   1    sync request re-asserted; terminates sequence
//  i_F                    in   8    octets per frame minus 1
//  i_K                    in   5    frames per multiframe minus 1
//  i_ila_multiframe_length in  8    ILAS multiframes minus 1
//  i_cfg                  in   112  config octets 0..13, octet n at [8n+7:8n]; octet 13 is ignored
//  o_data                 out  8    ILAS octet
//  o_k                    out  1    o_data is a control character
//  o_vld                  out  1    o_data/o_k valid
//  o_last                 out  1    high with the final /A/ octet
//  o_busy                 out  1    sequence in progress
//  o_cfg_err              out  1    sticky; start rejected on illegal config
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; counters 0. Reset mid-sequence -> outputs 0 immediately.
//  Latch on accepted start: mf_len = (i_F+1)*(i_K+1) (14b, no overflow); n_mf = i_ila_multiframe_length+1 (9b).
//  Config inputs sampled only at start; later changes ignored until next start.
//  Start accepted in IDLE only; ignored while RUN.
//  Start rejected if mf_len < 18 or i_ila_multiframe_length == 0: o_cfg_err <= 1, stay IDLE.
//  o_cfg_err clears on the next accepted start.
//  Latency: i_start at cycle n -> first /R/ on outputs at n+1. All outputs registered.
//  Octet index o (0..mf_len-1) in multiframe m (0..n_mf-1); one octet per cycle, no gaps.
//   o==0: /R/ K28.0 = 8'h1C, o_k=1.
//   o==mf_len-1: /A/ K28.3 = 8'h7C, o_k=1.
//   m==1, o==1: /Q/ K28.4 = 8'h9C, o_k=1.
//   m==1, o==2..14: i_cfg octet (o-2), o_k=0.
//   m==1, o==15: FCHK = sum of cfg octets 0..12 mod 256, o_k=0.
//   otherwise: o[7:0] (ramp filler), o_k=0.
//  FCHK is computed combinationally on the latched config; registered once at start.
//  Counter wrap: o==mf_len-1 -> o=0, m=m+1. At o==mf_len-1 and m==n_mf-1: o_last=1; next cycle -> IDLE.
//  Total octets per sequence = mf_len*n_mf.
//  States: IDLE --start ok--> RUN --last octet--> IDLE.
//  States: RUN --i_abort--> IDLE, with o_vld/o_busy low the next cycle and no o_last.
//  i_start and i_abort in the same cycle: abort wins, nothing starts.
//  o_busy = (state==RUN). Back-to-back start is accepted on the cycle after o_last.
// TESTING
//  F=7,K=3,len=3, start -> 128 octets.
//   Octet 0 is 1C/k; octets 31,63,95,127 are 7C/k; octet 33 is 9C/k.
//   o_last is asserted only on octet 127.
//  i_cfg octets = 8'h01..8'h0D (octets 0..12) -> octets 34..46 = 01..0D, octet 47 = FCHK 8'h5B.
//   Filler: octet 50 = 8'h12 (o=18).
//  i_abort at octet 40 -> o_vld=0 from the next cycle, o_last never asserted.
//   A new start then restarts at /R/.
//  F=0,K=3 (mf_len=4) start -> o_cfg_err=1, o_vld stays 0.
//   A later legal start clears o_cfg_err and runs.
//  i_start during RUN is ignored and the count is unaffected.
//   i_start together with i_abort in IDLE -> nothing starts.
//  Assert rst mid-sequence -> all outputs 0 asynchronously.
//   After release, a start produces a full sequence with correct counts.

Source files
------------

// File: rtl/tx_ilas_sequencer.sv
// JESD204B transmit ILAS generator: /R/ ... /A/ framed multiframes, with /Q/, link config
// and FCHK in the second multiframe. One octet per character clock; all outputs registered.
module tx_ilas_sequencer #(
  parameter int CFG_OCTETS = 14,
  parameter int MFLEN_W    = 14
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_start,
  input  logic                    i_abort,
  input  logic [7:0]              i_F,
  input  logic [4:0]              i_K,
  input  logic [7:0]              i_ila_multiframe_length,
  input  logic [CFG_OCTETS*8-1:0] i_cfg,
  output logic [7:0]              o_data,
  output logic                    o_k,
  output logic                    o_vld,
  output logic                    o_last,
  output logic                    o_busy,
  output logic                    o_cfg_err
);

  localparam logic [7:0] K_R = 8'h1C;
  localparam logic [7:0] K_A = 8'h7C;
  localparam logic [7:0] K_Q = 8'h9C;

  localparam logic [MFLEN_W-1:0] MIN_MF_LEN = MFLEN_W'(18);
  localparam logic [MFLEN_W-1:0] OCT_Q      = MFLEN_W'(1);
  localparam logic [MFLEN_W-1:0] OCT_CFG_LO = MFLEN_W'(2);
  localparam logic [MFLEN_W-1:0] OCT_CFG_HI = MFLEN_W'(CFG_OCTETS);
  localparam logic [MFLEN_W-1:0] OCT_FCHK   = MFLEN_W'(CFG_OCTETS + 1);

  // Octet 13 of the config word is not transmitted; only octets 0..12 are kept.
  typedef logic [CFG_OCTETS-2:0][7:0] cfg_t;

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state, state_nx;
  logic [MFLEN_W-1:0] oct, oct_nx;
  logic [8:0]         mf, mf_nx;
  logic [MFLEN_W-1:0] mf_len_q;
  logic [8:0]         n_mf_q;
  cfg_t               cfg_q;
  logic [7:0]         fchk_q;

  logic [7:0]         data_p1, data_nx;
  logic               k_p1, k_nx;
  logic               vld_p1, vld_nx;
  logic               last_p1, last_nx;
  logic               cfg_err_p1, cfg_err_nx;
  logic               latch;

  cfg_t               cfg_in;
  logic               cfg_unused;
  logic [MFLEN_W-1:0] f_plus, k_plus, start_len;
  logic               start_bad;
  logic [3:0]         cfg_idx;

  function automatic logic [7:0] fchk_sum(input cfg_t cfg);
    logic [7:0] s;
    s = 8'h00;
    for (int n = 0; n < CFG_OCTETS - 1; n++) s = s + cfg[n];
    return s;
  endfunction

  assign cfg_in     = i_cfg[(CFG_OCTETS-1)*8-1:0];
  assign cfg_unused = ^i_cfg[CFG_OCTETS*8-1 -: 8];

  // (F+1)*(K+1) is at most 256*32 = 8192, so the product never overflows MFLEN_W bits.
  assign f_plus    = MFLEN_W'(i_F) + MFLEN_W'(1);
  assign k_plus    = MFLEN_W'(i_K) + MFLEN_W'(1);
  assign start_len = f_plus * k_plus;
  assign start_bad = (start_len < MIN_MF_LEN) || (i_ila_multiframe_length == 8'd0);

  assign cfg_idx   = oct[3:0] - 4'd2;

  always_comb begin
    state_nx   = state;
    oct_nx     = oct;
    mf_nx      = mf;
    data_nx    = 8'h00;
    k_nx       = 1'b0;
    vld_nx     = 1'b0;
    last_nx    = 1'b0;
    cfg_err_nx = cfg_err_p1;
    latch      = 1'b0;
    unique case (state)
      IDLE: begin
        if (i_start && !i_abort) begin
          if (start_bad) begin
            cfg_err_nx = 1'b1;
          end else begin
            // Octet 0 of the first multiframe goes out on the accepting edge.
            latch      = 1'b1;
            cfg_err_nx = 1'b0;
            state_nx   = RUN;
            data_nx    = K_R;
            k_nx       = 1'b1;
            vld_nx     = 1'b1;
            oct_nx     = MFLEN_W'(1);
            mf_nx      = 9'd0;
          end
        end
      end
      RUN: begin
        if (i_abort || last_p1) begin
          state_nx = IDLE;
          oct_nx   = '0;
          mf_nx    = 9'd0;
        end else begin
          vld_nx = 1'b1;
          if (oct == mf_len_q - MFLEN_W'(1)) begin
            data_nx = K_A;
            k_nx    = 1'b1;
            if (mf == n_mf_q - 9'd1) begin
              last_nx = 1'b1;
            end else begin
              oct_nx = '0;
              mf_nx  = mf + 9'd1;
            end
          end else begin
            oct_nx = oct + MFLEN_W'(1);
            // The minimum legal multiframe (18 octets) keeps /Q/, config and FCHK clear of /A/.
            if (oct == '0) begin
              data_nx = K_R;
              k_nx    = 1'b1;
            end else if (mf == 9'd1 && oct == OCT_Q) begin
              data_nx = K_Q;
              k_nx    = 1'b1;
            end else if (mf == 9'd1 && oct >= OCT_CFG_LO && oct <= OCT_CFG_HI) begin
              data_nx = cfg_q[cfg_idx];
            end else if (mf == 9'd1 && oct == OCT_FCHK) begin
              data_nx = fchk_q;
            end else begin
              data_nx = oct[7:0];
            end
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Stage p1: registered control, counters and output octet
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      oct        <= '0;
      mf         <= 9'd0;
      data_p1    <= 8'h00;
      k_p1       <= 1'b0;
      vld_p1     <= 1'b0;
      last_p1    <= 1'b0;
      cfg_err_p1 <= 1'b0;
    end else begin
      state      <= state_nx;
      oct        <= oct_nx;
      mf         <= mf_nx;
      data_p1    <= data_nx;
      k_p1       <= k_nx;
      vld_p1     <= vld_nx;
      last_p1    <= last_nx;
      cfg_err_p1 <= cfg_err_nx;
    end
  end

  // Stage p1: link configuration captured once per accepted start
  always_ff @(posedge clk) begin
    if (latch) begin
      cfg_q    <= cfg_in;
      fchk_q   <= fchk_sum(cfg_in);
      mf_len_q <= start_len;
      n_mf_q   <= {1'b0, i_ila_multiframe_length} + 9'd1;
    end
  end

  assign o_data    = data_p1;
  assign o_k       = k_p1;
  assign o_vld     = vld_p1;
  assign o_last    = last_p1;
  assign o_busy    = (state == RUN);
  assign o_cfg_err = cfg_err_p1;

endmodule

// File: tb/tb_tx_ilas_sequencer.sv
// Bench for tx_ilas_sequencer: index-arithmetic reference model checked every cycle,
// plus literal expectations on captured octets of the reference configuration.
module tb_tx_ilas_sequencer;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         i_start = 1'b0;
  logic         i_abort = 1'b0;
  logic [7:0]   i_F = 8'd0;
  logic [4:0]   i_K = 5'd0;
  logic [7:0]   i_ila_multiframe_length = 8'd0;
  logic [111:0] i_cfg = '0;
  logic [7:0]   o_data;
  logic         o_k, o_vld, o_last, o_busy, o_cfg_err;

  always #5 clk = ~clk;

  tx_ilas_sequencer dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_abort(i_abort),
    .i_F(i_F), .i_K(i_K), .i_ila_multiframe_length(i_ila_multiframe_length),
    .i_cfg(i_cfg), .o_data(o_data), .o_k(o_k), .o_vld(o_vld), .o_last(o_last),
    .o_busy(o_busy), .o_cfg_err(o_cfg_err)
  );

  int checks = 0;
  int fails  = 0;

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: sequence position as a flat octet index t
  bit         m_run = 1'b0;
  bit         m_err = 1'b0;
  int         m_t = 0, m_len = 0, m_nmf = 0, m_tmp = 0;
  logic [7:0] m_cfg [13];

  function automatic logic [8:0] exp_oct(input int t);
    int o, m, s;
    o = t % m_len;
    m = t / m_len;
    if (o == m_len - 1) return {1'b1, 8'h7C};
    if (o == 0) return {1'b1, 8'h1C};
    if (m == 1 && o == 1) return {1'b1, 8'h9C};
    if (m == 1 && o >= 2 && o <= 14) return {1'b0, m_cfg[o-2]};
    if (m == 1 && o == 15) begin
      s = 0;
      for (int n = 0; n < 13; n++) s += int'(m_cfg[n]);
      return {1'b0, 8'(s)};
    end
    return {1'b0, 8'(o)};
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_run = 1'b0;
      m_err = 1'b0;
      m_t   = 0;
    end else if (m_run) begin
      if (i_abort || m_t == m_len * m_nmf - 1) m_run = 1'b0;
      else m_t++;
    end else if (i_start && !i_abort) begin
      m_tmp = (int'(i_F) + 1) * (int'(i_K) + 1);
      if (m_tmp < 18 || i_ila_multiframe_length == 8'd0) begin
        m_err = 1'b1;
      end else begin
        m_err = 1'b0;
        m_run = 1'b1;
        m_t   = 0;
        m_len = m_tmp;
        m_nmf = int'(i_ila_multiframe_length) + 1;
        for (int n = 0; n < 13; n++) m_cfg[n] = i_cfg[8*n +: 8];
      end
    end
  end

  // Per-cycle comparison and capture of valid octets
  bit         chk_en = 1'b0;
  logic [12:0] c_act, c_exp;
  logic [8:0]  c_e;
  logic [8:0]  cap [0:1023];
  bit          cap_last [0:1023];
  int          cap_n = 0;

  always @(negedge clk) begin
    if (chk_en) begin
      if (m_run) begin
        c_e   = exp_oct(m_t);
        c_exp = {1'b1, c_e[8], (m_t == m_len * m_nmf - 1), 1'b1, m_err, c_e[7:0]};
      end else begin
        c_exp = {4'b0000, m_err, 8'h00};
      end
      c_act = {o_vld, o_vld & o_k, o_last, o_busy, o_cfg_err, (o_vld ? o_data : 8'h00)};
      check("cycle", int'(c_act), int'(c_exp));
      if (o_vld && cap_n < 1024) begin
        cap[cap_n]      = {o_k, o_data};
        cap_last[cap_n] = o_last;
        cap_n++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int f, input int k, input int l, input logic [111:0] cfg);
    i_F = 8'(f);
    i_K = 5'(k);
    i_ila_multiframe_length = 8'(l);
    i_cfg = cfg;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    i_F = 8'($urandom);
    i_K = 5'($urandom);
    i_ila_multiframe_length = 8'($urandom);
    i_cfg = 112'({$urandom, $urandom, $urandom, $urandom});
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (m_run && n < 20000) begin tick(); n++; end
    if (m_run) begin
      checks++;
      fails++;
      $display("FAIL wait_idle: still running after %0d cycles, expected idle", n);
    end
  endtask

  task automatic wait_last();
    int n;
    n = 0;
    while (!(m_run && m_t == m_len * m_nmf - 1) && n < 20000) begin tick(); n++; end
    if (n >= 20000) begin
      checks++;
      fails++;
      $display("FAIL wait_last: no final octet after %0d cycles", n);
    end
  endtask

  logic [111:0] ref_cfg;
  int           nl, li;

  initial begin
    for (int n = 0; n < 13; n++) ref_cfg[8*n +: 8] = 8'(n + 1);
    ref_cfg[111:104] = 8'hEE;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk_en = 1'b1;
    check("reset_state", int'({o_vld, o_k, o_last, o_busy, o_cfg_err, o_data}), 0);
    tick();

    // Reference run F=7 K=3 len=3, with an ignored start mid-sequence
    cap_n = 0;
    do_start(7, 3, 3, ref_cfg);
    repeat (60) tick();
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    wait_idle();
    check("ref_count", cap_n, 128);
    check("oct0_R", int'(cap[0]), 'h11C);
    check("oct31_A", int'(cap[31]), 'h17C);
    check("oct63_A", int'(cap[63]), 'h17C);
    check("oct95_A", int'(cap[95]), 'h17C);
    check("oct127_A", int'(cap[127]), 'h17C);
    check("oct33_Q", int'(cap[33]), 'h19C);
    check("oct34_cfg0", int'(cap[34]), 'h001);
    check("oct46_cfg12", int'(cap[46]), 'h00D);
    check("oct47_fchk", int'(cap[47]), 'h05B);
    check("oct50_fill", int'(cap[50]), 'h012);
    nl = 0;
    li = -1;
    for (int n = 0; n < cap_n; n++) if (cap_last[n]) begin nl++; li = n; end
    check("last_count", nl, 1);
    check("last_index", li, 127);
    tick();

    // Abort while octet 40 is on the output, then restart
    cap_n = 0;
    do_start(7, 3, 3, ref_cfg);
    repeat (40) tick();
    i_abort = 1'b1;
    tick();
    i_abort = 1'b0;
    check("abort_vld", int'({o_vld, o_busy, o_last}), 0);
    repeat (3) tick();
    check("abort_count", cap_n, 41);
    nl = 0;
    for (int n = 0; n < cap_n; n++) if (cap_last[n]) nl++;
    check("abort_no_last", nl, 0);
    cap_n = 0;
    do_start(7, 3, 3, ref_cfg);
    check("restart_R", int'({o_vld, o_k, o_data}), 'h31C);
    wait_idle();
    check("restart_count", cap_n, 128);
    tick();

    // Illegal configurations, then a legal start clears the error
    cap_n = 0;
    do_start(0, 3, 3, ref_cfg);
    check("err_set", int'({o_cfg_err, o_vld}), 'h2);
    repeat (3) tick();
    check("err_no_octets", cap_n, 0);
    do_start(7, 3, 0, ref_cfg);
    check("err_len0", int'({o_cfg_err, o_vld}), 'h2);
    do_start(8, 1, 1, ref_cfg);
    check("err_clear", int'({o_cfg_err, o_vld}), 'h1);
    wait_last();
    tick();
    check("min_count", cap_n, 36);
    cap_n = 0;
    do_start(8, 1, 1, ref_cfg);
    check("b2b_R", int'({o_vld, o_k, o_data}), 'h31C);
    wait_idle();
    check("b2b_count", cap_n, 36);

    // Start and abort together in idle
    i_start = 1'b1;
    i_abort = 1'b1;
    tick();
    i_start = 1'b0;
    i_abort = 1'b0;
    check("start_abort", int'({o_vld, o_busy}), 0);
    tick();

    // Asynchronous reset mid-sequence, then a clean full run
    do_start(7, 3, 3, ref_cfg);
    repeat (20) tick();
    #2 rst = 1'b1;
    #1 check("rst_async", int'({o_vld, o_k, o_last, o_busy, o_cfg_err, o_data}), 0);
    #3 rst = 1'b0;
    tick();
    cap_n = 0;
    do_start(3, 7, 1, ref_cfg);
    wait_idle();
    check("post_rst_count", cap_n, 64);
    tick();

    // Randomized configurations with sporadic aborts and ignored starts
    for (int it = 0; it < 12; it++) begin
      do_start(int'($urandom_range(0, 15)), int'($urandom_range(0, 7)),
               int'($urandom_range(0, 3)), 112'({$urandom, $urandom, $urandom, $urandom}));
      while (m_run) begin
        i_start = ($urandom_range(0, 15) == 0);
        i_abort = ($urandom_range(0, 199) == 0);
        tick();
      end
      i_start = 1'b0;
      i_abort = 1'b0;
      wait_idle();
      repeat (2) tick();
    end

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
